// File: rtl/parking_meter_if.sv
// Bundles the parking meter's request inputs and display outputs.
// The master side drives the buttons and presets. The slave side is the countdown core.
interface parking_meter_if #(
  parameter int DIGITS = 4
) ();

  logic [3:0]          add_pulse;
  logic [1:0]          preset;
  logic [4*DIGITS-1:0] bcd;
  logic                blank;
  logic                expired;
  logic                tick;

  modport master (
    output add_pulse, preset,
    input  bcd, blank, expired, tick
  );

  modport slave (
    input  add_pulse, preset,
    output bcd, blank, expired, tick
  );

endinterface

// File: rtl/parking_meter_core.sv
// Countdown core for the parking meter display.
// Holds the remaining time as packed BCD and handles the once-per-second tick,
// the button adds, the preset loads and the low-time/expired flash blanking.
module parking_meter_core #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000000,
  parameter int INC0     = 50,
  parameter int INC1     = 150,
  parameter int INC2     = 200,
  parameter int INC3     = 500,
  parameter int PRESET0  = 15,
  parameter int PRESET1  = 185,
  parameter int LOW_THR  = 200
) (
  input  logic          fastclk,
  input  logic          rst,
  parking_meter_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = $clog2(TICK_DIV);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint MAXV = pow10(DIGITS) - 1;

  // Converts a constant to BCD, clamping anything above MAXV.
  function automatic logic [W-1:0] toBcd(input longint v);
    logic [W-1:0] r;
    longint       x;
    x = (v > MAXV) ? MAXV : ((v < 0) ? 0 : v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W:0] bcdAdd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0]   s;
    logic         c;
    logic [W-1:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      c = (s > 5'd9);
      r[4*i +: 4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return {c, r};
  endfunction

  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic         borrow;
    r      = a;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (a[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = a[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD     = toBcd(MAXV);
  localparam logic [W-1:0] INC0_BCD    = toBcd(longint'(INC0));
  localparam logic [W-1:0] INC1_BCD    = toBcd(longint'(INC1));
  localparam logic [W-1:0] INC2_BCD    = toBcd(longint'(INC2));
  localparam logic [W-1:0] INC3_BCD    = toBcd(longint'(INC3));
  localparam logic [W-1:0] PRESET0_BCD = toBcd(longint'(PRESET0));
  localparam logic [W-1:0] PRESET1_BCD = toBcd(longint'(PRESET1));
  localparam logic [W-1:0] LOW_BCD     = toBcd(longint'(LOW_THR));

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2 - 1);

  logic [W-1:0]     bcd_q, bcd_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             secOdd_q, secOdd_d;

  logic [W-1:0] incSel;
  logic         addHit;
  logic         loadHit;
  logic [W:0]   sum;
  logic [W-1:0] addResult;

  // Next-state logic: presets beat adds, adds beat a plain tick decrement.
  always_comb begin
    incSel  = '0;
    addHit  = 1'b1;
    loadHit = |bus.preset;
    if (bus.add_pulse[0])      incSel = INC0_BCD;
    else if (bus.add_pulse[1]) incSel = INC1_BCD;
    else if (bus.add_pulse[2]) incSel = INC2_BCD;
    else if (bus.add_pulse[3]) incSel = INC3_BCD;
    else                       addHit = 1'b0;

    // A carry out means the sum is at least 10^DIGITS, so even after a tick it saturates.
    sum = bcdAdd(bcd_q, incSel);
    if (sum[W])
      addResult = MAX_BCD;
    else if (tick_q && (sum[W-1:0] != '0))
      addResult = bcdDec(sum[W-1:0]);
    else
      addResult = sum[W-1:0];

    if (bus.preset[0])                bcd_d = PRESET0_BCD;
    else if (bus.preset[1])           bcd_d = PRESET1_BCD;
    else if (addHit)                  bcd_d = addResult;
    else if (tick_q && bcd_q != '0)   bcd_d = bcdDec(bcd_q);
    else                              bcd_d = bcd_q;

    if (loadHit || div_q == DIV_LAST) div_d = '0;
    else                              div_d = div_q + 1'b1;

    tick_d   = (div_d == DIV_LAST);
    phase_d  = loadHit ? 1'b0 : (phase_q ^ ((div_q == DIV_HALF) || (div_q == DIV_LAST)));
    secOdd_d = loadHit ? 1'b0 : (secOdd_q ^ tick_q);
  end

  always_ff @(posedge fastclk) begin
    if (rst) begin
      bcd_q    <= '0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      phase_q  <= 1'b0;
      secOdd_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      secOdd_q <= secOdd_d;
    end
  end

  // Expired flashes at the half-second rate, low time flashes on odd seconds.
  always_comb begin
    if (bcd_q == '0)          bus.blank = phase_q;
    else if (bcd_q < LOW_BCD) bus.blank = secOdd_q;
    else                      bus.blank = 1'b0;
  end

  assign bus.bcd     = bcd_q;
  assign bus.tick    = tick_q;
  assign bus.expired = (bcd_q == '0);

endmodule

// File: tb/tb_parking_meter_core.sv
// Directed bench for parking_meter_core with a 10-cycle second and four BCD digits.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at the same point.
module tb_parking_meter_core;

  logic fastclk;
  logic rst;
  int   errors;
  int   checks;

  parking_meter_if #(.DIGITS(4)) bus ();

  parking_meter_core #(
    .DIGITS(4), .TICK_DIV(10), .INC0(50), .INC1(150), .INC2(200), .INC3(500),
    .PRESET0(15), .PRESET1(185), .LOW_THR(200)
  ) dut (
    .fastclk (fastclk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fastclk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic expTick;
    logic expBlank;
    doReset();
    checks++;
    if (bus.bcd !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd got=%h want=0000", bus.bcd); end
    checks++;
    if (bus.expired !== 1'b1) begin errors++; $display("[TB] FAIL reset_expired got=%b want=1", bus.expired); end
    checks++;
    if (bus.blank !== 1'b0) begin errors++; $display("[TB] FAIL reset_blank got=%b want=0", bus.blank); end
    checks++;
    if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%b want=0", bus.tick); end
    // Divider position k%10: tick at 9, expired blank in the second half of each second.
    for (int k = 1; k <= 20; k++) begin
      step(1);
      expTick  = ((k % 10) == 9);
      expBlank = ((k % 10) >= 5);
      checks++;
      if (bus.tick !== expTick) begin errors++; $display("[TB] FAIL idle_tick k=%0d got=%b want=%b", k, bus.tick, expTick); end
      checks++;
      if (bus.blank !== expBlank) begin errors++; $display("[TB] FAIL idle_blank k=%0d got=%b want=%b", k, bus.blank, expBlank); end
    end
    checks++;
    if (bus.bcd !== 16'h0000) begin errors++; $display("[TB] FAIL idle_no_wrap got=%h want=0000", bus.bcd); end
  endtask

  task automatic test_countdown();
    bus.preset = 2'b01;
    step(1);
    bus.preset = 2'b00;
    checks++;
    if (bus.bcd !== 16'h0015) begin errors++; $display("[TB] FAIL preset0_load got=%h want=0015", bus.bcd); end
    checks++;
    if (bus.blank !== 1'b0) begin errors++; $display("[TB] FAIL low_blank_even got=%b want=0", bus.blank); end
    step(10);
    checks++;
    if (bus.bcd !== 16'h0014) begin errors++; $display("[TB] FAIL first_tick got=%h want=0014", bus.bcd); end
    checks++;
    if (bus.blank !== 1'b1) begin errors++; $display("[TB] FAIL low_blank_odd got=%b want=1", bus.blank); end
    step(10);
    checks++;
    if (bus.blank !== 1'b0) begin errors++; $display("[TB] FAIL low_blank_even2 got=%b want=0", bus.blank); end
    step(130);
    checks++;
    if (bus.bcd !== 16'h0000) begin errors++; $display("[TB] FAIL countdown_zero got=%h want=0000", bus.bcd); end
    checks++;
    if (bus.expired !== 1'b1) begin errors++; $display("[TB] FAIL countdown_expired got=%b want=1", bus.expired); end
    step(50);
    checks++;
    if (bus.bcd !== 16'h0000) begin errors++; $display("[TB] FAIL expired_hold got=%h want=0000", bus.bcd); end
  endtask

  task automatic test_adds();
    bus.preset = 2'b10;
    step(1);
    bus.preset = 2'b00;
    checks++;
    if (bus.bcd !== 16'h0185) begin errors++; $display("[TB] FAIL preset1_load got=%h want=0185", bus.bcd); end
    bus.add_pulse = 4'b0001;
    step(1);
    checks++;
    if (bus.bcd !== 16'h0235) begin errors++; $display("[TB] FAIL add_inc0 got=%h want=0235", bus.bcd); end
    bus.add_pulse = 4'b1010;
    step(1);
    checks++;
    if (bus.bcd !== 16'h0385) begin errors++; $display("[TB] FAIL add_lowest_wins got=%h want=0385", bus.bcd); end
    checks++;
    if (bus.blank !== 1'b0) begin errors++; $display("[TB] FAIL normal_blank got=%b want=0", bus.blank); end
    bus.add_pulse = 4'b1100;
    step(1);
    checks++;
    if (bus.bcd !== 16'h0585) begin errors++; $display("[TB] FAIL add_inc2 got=%h want=0585", bus.bcd); end
    bus.add_pulse = 4'b1000;
    step(1);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h1085) begin errors++; $display("[TB] FAIL add_inc3_carry got=%h want=1085", bus.bcd); end
  endtask

  task automatic test_saturation();
    doReset();
    bus.add_pulse = 4'b1000;
    step(9);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h4500) begin errors++; $display("[TB] FAIL sat_build1 got=%h want=4500", bus.bcd); end
    checks++;
    if (bus.tick !== 1'b1) begin errors++; $display("[TB] FAIL sat_tick_seen got=%b want=1", bus.tick); end
    step(1);
    checks++;
    if (bus.bcd !== 16'h4499) begin errors++; $display("[TB] FAIL sat_tick_dec got=%h want=4499", bus.bcd); end
    bus.add_pulse = 4'b1000;
    step(9);
    checks++;
    if (bus.bcd !== 16'h8999) begin errors++; $display("[TB] FAIL sat_build2 got=%h want=8999", bus.bcd); end
    bus.add_pulse = 4'b0001;
    step(1);
    checks++;
    if (bus.bcd !== 16'h9048) begin errors++; $display("[TB] FAIL add_with_tick got=%h want=9048", bus.bcd); end
    bus.add_pulse = 4'b1000;
    step(2);
    checks++;
    if (bus.bcd !== 16'h9999) begin errors++; $display("[TB] FAIL saturate_add got=%h want=9999", bus.bcd); end
    bus.add_pulse = 4'b0100;
    step(1);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h9999) begin errors++; $display("[TB] FAIL saturate_hold got=%h want=9999", bus.bcd); end
    step(87);
    checks++;
    if (bus.bcd !== 16'h9990) begin errors++; $display("[TB] FAIL nine_ticks got=%h want=9990", bus.bcd); end
    bus.add_pulse = 4'b0001;
    step(1);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h9999) begin errors++; $display("[TB] FAIL sat_9990_plus_50 got=%h want=9999", bus.bcd); end
    step(8);
    checks++;
    if (bus.tick !== 1'b1) begin errors++; $display("[TB] FAIL sat_tick_align got=%b want=1", bus.tick); end
    bus.add_pulse = 4'b0001;
    step(1);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h9999) begin errors++; $display("[TB] FAIL sat_add_tick got=%h want=9999", bus.bcd); end
    step(10);
    checks++;
    if (bus.bcd !== 16'h9998) begin errors++; $display("[TB] FAIL sat_then_dec got=%h want=9998", bus.bcd); end
  endtask

  task automatic test_borrow();
    doReset();
    bus.add_pulse = 4'b1000;
    step(2);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h1000) begin errors++; $display("[TB] FAIL build_1000 got=%h want=1000", bus.bcd); end
    step(8);
    checks++;
    if (bus.bcd !== 16'h0999) begin errors++; $display("[TB] FAIL borrow_1000 got=%h want=0999", bus.bcd); end
    checks++;
    if (bus.blank !== 1'b0) begin errors++; $display("[TB] FAIL blank_0999 got=%b want=0", bus.blank); end
    doReset();
    bus.add_pulse = 4'b0001;
    step(2);
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h0100) begin errors++; $display("[TB] FAIL back_to_back_adds got=%h want=0100", bus.bcd); end
    step(8);
    checks++;
    if (bus.bcd !== 16'h0099) begin errors++; $display("[TB] FAIL borrow_0100 got=%h want=0099", bus.bcd); end
    checks++;
    if (bus.blank !== 1'b1) begin errors++; $display("[TB] FAIL blank_0099 got=%b want=1", bus.blank); end
  endtask

  task automatic test_presets_and_reset();
    bus.preset = 2'b11;
    step(1);
    checks++;
    if (bus.bcd !== 16'h0015) begin errors++; $display("[TB] FAIL both_presets got=%h want=0015", bus.bcd); end
    bus.preset = 2'b01;
    step(15);
    checks++;
    if (bus.bcd !== 16'h0015) begin errors++; $display("[TB] FAIL held_preset got=%h want=0015", bus.bcd); end
    bus.preset = 2'b10;
    step(1);
    bus.preset = 2'b00;
    step(620);
    checks++;
    if (bus.bcd !== 16'h0123) begin errors++; $display("[TB] FAIL reach_0123 got=%h want=0123", bus.bcd); end
    rst = 1'b1;
    bus.preset = 2'b01;
    bus.add_pulse = 4'b1111;
    step(1);
    rst = 1'b0;
    bus.preset = 2'b00;
    bus.add_pulse = 4'b0000;
    checks++;
    if (bus.bcd !== 16'h0000) begin errors++; $display("[TB] FAIL mid_reset got=%h want=0000", bus.bcd); end
    checks++;
    if (bus.expired !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_expired got=%b want=1", bus.expired); end
    step(8);
    checks++;
    if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_early_tick got=%b want=0", bus.tick); end
    step(1);
    checks++;
    if (bus.tick !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_tick got=%b want=1", bus.tick); end
  endtask

  // Scenarios run back to back, each leaving inputs idle for the next.
  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.add_pulse = 4'b0000;
    bus.preset    = 2'b00;
    test_reset();
    test_countdown();
    test_adds();
    test_saturation();
    test_borrow();
    test_presets_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
